// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed display scanner.
package seg_scan_pkg;

    // One-hot style encoding so a corrupted state register is detectable.
    typedef enum logic [1:0] {
        SHOW = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam int unsigned BCD_MAX = 9;

    // Width of an index/counter covering 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display bus between a counter/timer datapath and the digit scanner.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    import seg_scan_pkg::*;

    localparam int unsigned IDX_W = idx_width(DIGITS);

    logic [4*DIGITS-1:0] data;
    logic                load;
    logic                lz_en;
    logic [3:0]          digit_val;
    logic [DIGITS-1:0]   digit_sel;
    logic                blank;
    logic [IDX_W-1:0]    scan_idx;

    modport master (
        output data, load, lz_en,
        input  digit_val, digit_sel, blank, scan_idx
    );

    modport slave (
        input  data, load, lz_en,
        output digit_val, digit_sel, blank, scan_idx
    );

endinterface

// File: rtl/seg_lz_mask.sv
// Per-digit blanking mask: non-BCD nibbles and (optionally) leading zeros.
module seg_lz_mask
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] shadow,
    input  logic                lz_en,
    output logic [DIGITS-1:0]   blank_mask
);

    logic       zero_run;
    logic [3:0] nib;

    // Walk from the most significant digit down, tracking whether every
    // nibble seen so far is zero; digit 0 is never zero-suppressed.
    always_comb begin
        zero_run   = 1'b1;
        nib        = '0;
        blank_mask = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib      = shadow[4*(DIGITS-1-k) +: 4];
            zero_run = zero_run && (nib == 4'd0);
            blank_mask[DIGITS-1-k] = (nib > 4'(BCD_MAX)) ||
                                     (lz_en && (k != DIGITS-1) && zero_run);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scheduler for DIGITS common-anode digits sharing one
// BCD-to-7-segment decoder, with dead time between digits.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned GAP_CYC = 2
) (
    input logic            clk,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(DIGITS);
    localparam int unsigned PW    = idx_width(DIV);
    localparam int unsigned GW    = idx_width(GAP_CYC);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PW-1:0]    DIV_LAST = PW'(DIV - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;

    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]          val_q, val_d;
    logic                blank_q, blank_d;
    logic [DIGITS-1:0]   blank_mask;

    // Mask is evaluated on the post-edge shadow so a load and an lz_en
    // change both land on the outputs one cycle later, together.
    seg_lz_mask #(
        .DIGITS(DIGITS)
    ) u_mask (
        .shadow     (shadow_d),
        .lz_en      (bus.lz_en),
        .blank_mask (blank_mask)
    );

    // Scan sequencing: dark gap, then one digit lit for DIV cycles.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pcnt_d   = pcnt_q;
        gcnt_d   = gcnt_q;
        shadow_d = bus.load ? bus.data : shadow_q;
        case (state_q)
            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = SHOW;
                    pcnt_d  = '0;
                    idx_d   = (idx_q >= IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (pcnt_q == DIV_LAST) begin
                    state_d = GAP;
                    gcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = GAP;
                gcnt_d  = '0;
                pcnt_d  = '0;
            end
        endcase
    end

    // Outputs are precomputed from next-state values and registered, so
    // they line up with the state registers without any input-to-pin path.
    always_comb begin
        sel_d   = '1;
        val_d   = '0;
        blank_d = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                val_d = shadow_d[4*i +: 4];
                if (state_d == SHOW) begin
                    sel_d[i] = 1'b0;
                    blank_d  = blank_mask[i];
                end
            end
        end
    end

    // State, counters, shadow word and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GAP;
            idx_q    <= IDX_LAST;
            pcnt_q   <= '0;
            gcnt_q   <= '0;
            shadow_q <= '0;
            sel_q    <= '1;
            val_q    <= '0;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pcnt_q   <= pcnt_d;
            gcnt_q   <= gcnt_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
            blank_q  <= blank_d;
        end
    end

    assign bus.digit_sel = sel_q;
    assign bus.digit_val = val_q;
    assign bus.blank     = blank_q;
    assign bus.scan_idx  = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=8, GAP_CYC=2.
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    seg_scan_ctrl_if #(.DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .DIGITS  (4),
        .DIV     (8),
        .GAP_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        lz;
        logic [3:0]  blk;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) until digit d is lit; sampled on negedges.
    task automatic wait_sel(input int d, output logic ok);
        logic [3:0] want;
        want = ~(4'b0001 << d);
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (bus.digit_sel === want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_sel actual=%0h expected=%0h (timeout)", bus.digit_sel, want);
        end
    endtask

    // Called at the negedge of the first cycle after a reset edge, with the
    // shadow word zero and lz_en low. Checks the exact per-cycle schedule.
    task automatic check_frame(input int ncyc);
        int slot, k;
        logic [3:0] esel;
        logic       eblk;
        logic [1:0] eidx;
        for (int c = 0; c < ncyc; c++) begin
            slot = c / 10;
            k    = c % 10;
            if (k < 2) begin
                esel = 4'hF;
                eblk = 1'b1;
                eidx = 2'((slot + 3) % 4);
            end else begin
                esel = ~(4'b0001 << (slot % 4));
                eblk = 1'b0;
                eidx = 2'(slot % 4);
            end
            chk("frame_sel", 32'(bus.digit_sel), 32'(esel));
            chk("frame_blank", 32'(bus.blank), 32'(eblk));
            chk("frame_idx", 32'(bus.scan_idx), 32'(eidx));
            chk("frame_val", 32'(bus.digit_val), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic ok;
        logic [3:0] seq5 [6];

        vecs[0] = '{data: 16'h1234, lz: 1'b0, blk: 4'b0000};
        vecs[1] = '{data: 16'h0050, lz: 1'b1, blk: 4'b1100};
        vecs[2] = '{data: 16'h0000, lz: 1'b1, blk: 4'b1110};
        vecs[3] = '{data: 16'hA9F3, lz: 1'b0, blk: 4'b1010};
        vecs[4] = '{data: 16'h0000, lz: 1'b0, blk: 4'b0000};
        vecs[5] = '{data: 16'h0907, lz: 1'b1, blk: 4'b1000};
        vecs[6] = '{data: 16'h1000, lz: 1'b1, blk: 4'b0000};

        seq5[0] = 4'b1011; seq5[1] = 4'b1011; seq5[2] = 4'b1011;
        seq5[3] = 4'b1111; seq5[4] = 4'b1111; seq5[5] = 4'b0111;

        rst      = 1'b1;
        bus.data = '0;
        bus.load = 1'b0;
        bus.lz_en = 1'b0;

        // Reset, release, and exact scan schedule over one frame plus a gap.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_frame(42);

        // Table-driven content/blanking checks for each digit.
        foreach (vecs[v]) begin
            bus.data  = vecs[v].data;
            bus.lz_en = vecs[v].lz;
            bus.load  = 1'b1;
            @(negedge clk);
            bus.load = 1'b0;
            for (int d = 0; d < 4; d++) begin
                wait_sel(d, ok);
                if (ok) begin
                    chk($sformatf("v%0d_val%0d", v, d), 32'(bus.digit_val),
                        32'((vecs[v].data >> (4*d)) & 16'hF));
                    chk($sformatf("v%0d_blank%0d", v, d), 32'(bus.blank), 32'(vecs[v].blk[d]));
                    chk($sformatf("v%0d_idx%0d", v, d), 32'(bus.scan_idx), d);
                end
            end
        end

        // Load mid-SHOW of digit 2: value changes next cycle, timing intact.
        bus.data  = 16'h1234;
        bus.lz_en = 1'b0;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        wait_sel(2, ok);
        chk("mid_val_old", 32'(bus.digit_val), 32'h2);
        repeat (3) @(negedge clk);
        chk("mid_sel_p3", 32'(bus.digit_sel), 32'hB);
        bus.data = 16'h1734;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("mid_val_new", 32'(bus.digit_val), 32'h7);
        chk("mid_sel_p4", 32'(bus.digit_sel), 32'hB);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("mid_seq%0d", i), 32'(bus.digit_sel), 32'(seq5[i]));
        end
        chk("mid_next_val", 32'(bus.digit_val), 32'h1);

        // Reset mid-SHOW of digit 2, with a competing load that must lose.
        wait_sel(2, ok);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        bus.data = 16'hFFFF;
        bus.load = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.load = 1'b0;
        check_frame(42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
